// File: rtl/serial_frame_tx.sv
// Framed serial transmitter: start bit (0), DATA_W data bits, stop bit (1).
// Each bit is held for BIT_CYCLES clocks; tx is driven straight from a flop.
module serial_frame_tx #(
   parameter int DATA_W     = 8,
   parameter int BIT_CYCLES = 1,
   parameter int LSB_FIRST  = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [DATA_W-1:0] i_din,
   input  logic              i_start,
   output logic              o_ready,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_tx
);

   localparam int             BW       = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [7:0]     CYC_LAST = 8'(BIT_CYCLES - 1);
   localparam logic [BW-1:0]  BIT_LAST = BW'(DATA_W - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t            r_state, w_state_nxt;
   logic [DATA_W-1:0] r_sh, w_sh_nxt, w_shifted;
   logic [BW-1:0]     r_bit, w_bit_nxt;
   logic [7:0]        r_cyc, w_cyc_nxt;
   logic              r_tx, w_tx_nxt;
   logic              r_done, w_done_nxt;
   logic              w_bit_end, w_out, w_shift_out;

   assign w_bit_end = (r_cyc == CYC_LAST);

   // The output end of the shift register depends on bit order.
   always_comb begin
      if (LSB_FIRST != 0) begin
         w_shifted   = r_sh >> 1;
         w_out       = r_sh[0];
         w_shift_out = w_shifted[0];
      end else begin
         w_shifted   = r_sh << 1;
         w_out       = r_sh[DATA_W-1];
         w_shift_out = w_shifted[DATA_W-1];
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= IDLE;
         r_sh    <= '0;
         r_bit   <= '0;
         r_cyc   <= '0;
         r_tx    <= 1'b1;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_sh    <= w_sh_nxt;
         r_bit   <= w_bit_nxt;
         r_cyc   <= w_cyc_nxt;
         r_tx    <= w_tx_nxt;
         r_done  <= w_done_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_sh_nxt    = r_sh;
      w_bit_nxt   = r_bit;
      w_cyc_nxt   = r_cyc;
      w_tx_nxt    = r_tx;
      w_done_nxt  = 1'b0;
      case (r_state)
         IDLE: begin
            w_tx_nxt = 1'b1;
            if (i_start) begin
               w_sh_nxt    = i_din;
               w_cyc_nxt   = '0;
               w_bit_nxt   = '0;
               w_tx_nxt    = 1'b0;
               w_state_nxt = START;
            end
         end
         START: begin
            if (w_bit_end) begin
               w_cyc_nxt   = '0;
               w_bit_nxt   = '0;
               w_tx_nxt    = w_out;
               w_state_nxt = DATA;
            end else begin
               w_cyc_nxt = r_cyc + 8'd1;
            end
         end
         DATA: begin
            if (w_bit_end) begin
               w_cyc_nxt = '0;
               if (r_bit == BIT_LAST) begin
                  w_tx_nxt    = 1'b1;
                  w_state_nxt = STOP;
               end else begin
                  w_bit_nxt = r_bit + 1'b1;
                  w_sh_nxt  = w_shifted;
                  w_tx_nxt  = w_shift_out;
               end
            end else begin
               w_cyc_nxt = r_cyc + 8'd1;
            end
         end
         STOP: begin
            if (w_bit_end) begin
               w_cyc_nxt   = '0;
               w_tx_nxt    = 1'b1;
               w_done_nxt  = 1'b1;
               w_state_nxt = IDLE;
            end else begin
               w_cyc_nxt = r_cyc + 8'd1;
            end
         end
         default: begin
            w_tx_nxt    = 1'b1;
            w_state_nxt = IDLE;
         end
      endcase
   end

   assign o_ready = (r_state == IDLE);
   assign o_busy  = ~o_ready;
   assign o_done  = r_done;
   assign o_tx    = r_tx;

endmodule
